// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe
//   Carries register tags and write-control bits from Decode through the
//   Execute, Memory and Writeback pipeline registers, and compares the
//   carried tags every cycle to produce the hazard unit's match vector.
//
// Parameters
//   REG_W   register-number width
//   PC_REG  register number that never produces a match (the PC)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset (clears all state)
//   RA1D/RA2D  Decode source registers
//   WA3D       Decode destination register
//   RegWriteD  Decode instruction writes WA3D
//   MemtoRegD  Decode instruction is a load
//   ValidD     Decode slot holds a real instruction
//   flushE     loads a bubble into Execute instead of the Decode fields
//   match      {M12D_E, M1E_M, M2E_M, M1E_W, M2E_W}
//   MemtoRegE  load in Execute
//   RegWriteM  write pending in Memory
//   RegWriteW  write pending in Writeback
//
// Optional feature (macro HAZARD_TAG_STATS_EN)
//   bubble_cnt   saturating count of cycles with flushE=1
//   loaduse_cnt  saturating count of cycles with match[4] & MemtoRegE
module hazard_tag_pipe #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             ValidD,
  input  logic             flushE,
  output logic [4:0]       match,
  output logic             MemtoRegE,
  output logic             RegWriteM,
  output logic             RegWriteW
`ifdef HAZARD_TAG_STATS_EN
  ,
  output logic [15:0]      bubble_cnt,
  output logic [15:0]      loaduse_cnt
`endif
);

  localparam logic [REG_W-1:0] PC_TAG = REG_W'(PC_REG);

  // A source equal to the PC never forwards, whatever the destination.
  function automatic logic tag_hit(input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dst);
    return (src == dst) && (src != PC_TAG);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Execute stage (_p0)
  logic [REG_W-1:0] ra1_p0, ra2_p0, wa3_p0;
  logic             rw_p0, mtr_p0, vld_p0;
  // Memory stage (_p1)
  logic [REG_W-1:0] wa3_p1;
  logic             rw_p1, vld_p1;
  // Writeback stage (_p2)
  logic [REG_W-1:0] wa3_p2;
  logic             rw_p2, vld_p2;

  // ---- Decode -> Execute ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flushE) begin
      ra1_p0 <= '0;
      ra2_p0 <= '0;
      wa3_p0 <= '0;
      rw_p0  <= 1'b0;
      mtr_p0 <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      ra1_p0 <= RA1D;
      ra2_p0 <= RA2D;
      wa3_p0 <= WA3D;
      rw_p0  <= RegWriteD & ValidD;
      mtr_p0 <= MemtoRegD & ValidD;
      vld_p0 <= ValidD;
    end
  end

  // ---- Execute -> Memory ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wa3_p1 <= '0;
      rw_p1  <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      wa3_p1 <= wa3_p0;
      rw_p1  <= rw_p0 & vld_p0;
      vld_p1 <= vld_p0;
    end
  end

  // ---- Memory -> Writeback ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wa3_p2 <= '0;
      rw_p2  <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      wa3_p2 <= wa3_p1;
      rw_p2  <= rw_p1 & vld_p1;
      vld_p2 <= vld_p1;
    end
  end

  // Write-control is deliberately left out of match; the hazard unit
  // qualifies each bit with the matching stage's RegWrite.
  always_comb begin
    match    = '0;
    match[4] = vld_p0 & ValidD & (tag_hit(RA1D, wa3_p0) | tag_hit(RA2D, wa3_p0));
    match[3] = vld_p0 & vld_p1 & tag_hit(ra1_p0, wa3_p1);
    match[2] = vld_p0 & vld_p1 & tag_hit(ra2_p0, wa3_p1);
    match[1] = vld_p0 & vld_p2 & tag_hit(ra1_p0, wa3_p2);
    match[0] = vld_p0 & vld_p2 & tag_hit(ra2_p0, wa3_p2);
  end

  assign MemtoRegE = mtr_p0;
  assign RegWriteM = rw_p1;
  assign RegWriteW = rw_p2;

`ifdef HAZARD_TAG_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt  <= 16'd0;
      loaduse_cnt <= 16'd0;
    end else begin
      if (flushE)
        bubble_cnt <= sat_inc(bubble_cnt);
      if (match[4] & mtr_p0)
        loaduse_cnt <= sat_inc(loaduse_cnt);
    end
  end
`endif

endmodule
